// File: rtl/jtopl_wrsched_pkg.sv
// Shared constants and types for the OPL host write scheduler.
//   OPL_AW_WAIT / OPL_DW_WAIT : YM3526 busy gaps (cen ticks) after address / data strobes
//   wr_req_t                  : one queued register write (register number, value)
package jtopl_wrsched_pkg;

    localparam int unsigned OPL_AW_WAIT = 12;
    localparam int unsigned OPL_DW_WAIT = 84;
    localparam int unsigned OPL_DEPTH   = 8;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_req_t;

    localparam int unsigned WR_REQ_W = $bits(wr_req_t);

    // Counter width able to hold the larger of the two waits (at least 1 bit)
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m == 0) ? 1 : int'($clog2(m + 1));
    endfunction

endpackage

// File: rtl/jtopl_wrfifo.sv
// Generic synchronous FIFO with registered occupancy flags.
//   clk, rst     : clock, synchronous active-high reset
//   push, din    : write request; refused when full, even with a same-cycle pop
//   pop, dout    : read request; dout shows the head entry
//   flush        : empty the FIFO; overrides push and pop
//   full, empty  : registered status
//   level        : registered occupancy; level_nxt_c is its next value
module jtopl_wrfifo #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Accepted operations and next occupancy
    always_comb begin
        push_ok     = push & ~full & ~flush;
        pop_ok      = pop & ~empty & ~flush;
        level_nxt_c = level;
        if (flush) begin
            level_nxt_c = '0;
        end else if (push_ok && !pop_ok) begin
            level_nxt_c = level + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            level_nxt_c = level - (AW+1)'(1);
        end
    end

    // Storage, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt_c;
            full  <= (level_nxt_c == (AW+1)'(DEPTH));
            empty <= (level_nxt_c == '0);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/jtopl_wrsched.sv
// Host-side register write scheduler for the OPL core. Queues (register, value)
// writes and replays each as an address strobe then a data strobe on the core
// bus, inserting the YM3526 busy gaps so requesters never poll status.
//   clk, rst, cen                 : clock, sync active-high reset, core clock enable
//   flush                         : drop queued writes; an in-flight write completes
//   req_valid/req_addr/req_data   : write request, accepted when req_ready
//   req_ready, level, busy        : FIFO not full, occupancy, activity
//   opl_addr/opl_din/opl_cs_n/opl_wr_n : core bus (addr 0 = address port, 1 = data port)
module jtopl_wrsched
    import jtopl_wrsched_pkg::*;
#(
    parameter int unsigned DEPTH     = OPL_DEPTH,
    parameter int unsigned AW_WAIT   = OPL_AW_WAIT,
    parameter int unsigned DW_WAIT   = OPL_DW_WAIT,
    parameter bit          SKIP_ADDR = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   flush,
    input  logic                   req_valid,
    input  logic [7:0]             req_addr,
    input  logic [7:0]             req_data,
    output logic                   req_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   opl_addr,
    output logic [7:0]             opl_din,
    output logic                   opl_cs_n,
    output logic                   opl_wr_n
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = cnt_width(AW_WAIT, DW_WAIT);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_A_STB  = 3'd1;
    localparam logic [2:0] ST_A_WAIT = 3'd2;
    localparam logic [2:0] ST_D_STB  = 3'd3;
    localparam logic [2:0] ST_D_WAIT = 3'd4;

    logic [2:0]          state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    wr_req_t             hold, hold_nxt;
    logic [7:0]          last_addr, last_addr_nxt;
    logic                last_vld, last_vld_nxt;
    logic                opl_addr_nxt;
    logic [7:0]          opl_din_nxt;
    logic                opl_cs_n_nxt;
    logic                pop_c;
    logic                push_c;
    wr_req_t             head;
    logic [WR_REQ_W-1:0] fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LW-1:0]       fifo_level_nxt;

    assign push_c = req_valid & req_ready & ~fifo_full;
    assign head   = wr_req_t'(fifo_dout);

    jtopl_wrfifo #(
        .DW    (WR_REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push_c),
        .pop         (pop_c),
        .flush       (flush),
        .din         ({req_addr, req_data}),
        .dout        (fifo_dout),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .level       (level),
        .level_nxt_c (fifo_level_nxt)
    );

    // Next-state and bus logic. A strobe ends on the edge after a cen=1 cycle
    // seen with cs_n already low, so it always spans exactly one cen tick. Wait
    // states leave on the tick that takes cnt to zero (or at once if cnt is 0)
    // and drop cs_n directly, so the gap between strobes is exactly the wait.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hold_nxt      = hold;
        last_addr_nxt = last_addr;
        last_vld_nxt  = last_vld;
        opl_addr_nxt  = opl_addr;
        opl_din_nxt   = opl_din;
        opl_cs_n_nxt  = opl_cs_n;
        pop_c         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !flush) begin
                    pop_c    = 1'b1;
                    hold_nxt = head;
                    if (SKIP_ADDR && last_vld && (head.addr == last_addr)) begin
                        state_nxt = ST_D_STB;
                    end else begin
                        state_nxt = ST_A_STB;
                    end
                end
            end
            ST_A_STB: begin
                opl_addr_nxt = 1'b0;
                opl_din_nxt  = hold.addr;
                opl_cs_n_nxt = 1'b0;
                if (!opl_cs_n && cen) begin
                    opl_cs_n_nxt  = 1'b1;
                    cnt_nxt       = CW'(AW_WAIT);
                    last_addr_nxt = hold.addr;
                    last_vld_nxt  = 1'b1;
                    state_nxt     = ST_A_WAIT;
                end
            end
            ST_A_WAIT: begin
                if ((cnt == '0) || (cen && (cnt == CW'(1)))) begin
                    opl_addr_nxt = 1'b1;
                    opl_din_nxt  = hold.data;
                    opl_cs_n_nxt = 1'b0;
                    state_nxt    = ST_D_STB;
                end else if (cen) begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_D_STB: begin
                opl_addr_nxt = 1'b1;
                opl_din_nxt  = hold.data;
                opl_cs_n_nxt = 1'b0;
                if (!opl_cs_n && cen) begin
                    opl_cs_n_nxt = 1'b1;
                    cnt_nxt      = CW'(DW_WAIT);
                    state_nxt    = ST_D_WAIT;
                end
            end
            ST_D_WAIT: begin
                if ((cnt == '0) || (cen && (cnt == CW'(1)))) begin
                    state_nxt = ST_IDLE;
                end else if (cen) begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                opl_cs_n_nxt = 1'b1;
                state_nxt    = ST_IDLE;
            end
        endcase

        // After a flush the core's address latch is not trusted
        if (flush) begin
            last_vld_nxt = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hold      <= '0;
            last_addr <= '0;
            last_vld  <= 1'b0;
            opl_addr  <= 1'b0;
            opl_din   <= '0;
            opl_cs_n  <= 1'b1;
            opl_wr_n  <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hold      <= hold_nxt;
            last_addr <= last_addr_nxt;
            last_vld  <= last_vld_nxt;
            opl_addr  <= opl_addr_nxt;
            opl_din   <= opl_din_nxt;
            opl_cs_n  <= opl_cs_n_nxt;
            opl_wr_n  <= opl_cs_n_nxt;
            busy      <= (state_nxt != ST_IDLE) || (fifo_level_nxt != '0);
            req_ready <= (fifo_level_nxt != LW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_jtopl_wrsched.sv
// Scoreboard bench for jtopl_wrsched: stimulus queues expected bus strobes,
// a negedge monitor checks each strobe's port, value, cen span and gap.
module tb_jtopl_wrsched;
    import jtopl_wrsched_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b1;
    logic       flush = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready;
    logic [3:0] level;
    logic       busy;
    logic       opl_addr;
    logic [7:0] opl_din;
    logic       opl_cs_n;
    logic       opl_wr_n;

    int total = 0;
    int bad   = 0;
    int cen_div = 1;

    typedef struct {
        int a;
        int d;
        int gap_cen;   // exact cen ticks before this strobe, -1 = unchecked
        int gap_clk;   // exact clocks before this strobe, -1 = unchecked
        int min_gap;   // minimum cen ticks before this strobe
    } exp_t;
    exp_t sb[$];

    jtopl_wrsched #(
        .DEPTH     (8),
        .AW_WAIT   (OPL_AW_WAIT),
        .DW_WAIT   (OPL_DW_WAIT),
        .SKIP_ADDR (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .flush     (flush),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .level     (level),
        .busy      (busy),
        .opl_addr  (opl_addr),
        .opl_din   (opl_din),
        .opl_cs_n  (opl_cs_n),
        .opl_wr_n  (opl_wr_n)
    );

    always #5 clk = ~clk;

    // cen pattern: every cen_div-th clock, never when cen_div is 0
    initial begin
        int ccnt = 0;
        forever begin
            @(posedge clk);
            #1;
            ccnt++;
            cen = (cen_div != 0) && ((ccnt % ((cen_div != 0) ? cen_div : 1)) == 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int a, input int d);
        req_valid = 1'b1;
        req_addr  = 8'(a);
        req_data  = 8'(d);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Queue the strobes one write should produce
    task automatic exp_wr(input int a, input int d, input bit send_addr,
                          input int lead_min, input int aw_clk);
        if (send_addr) begin
            sb.push_back('{a: 0, d: a, gap_cen: -1, gap_clk: -1, min_gap: lead_min});
            sb.push_back('{a: 1, d: d, gap_cen: int'(OPL_AW_WAIT), gap_clk: aw_clk, min_gap: 0});
        end else begin
            sb.push_back('{a: 1, d: d, gap_cen: -1, gap_clk: -1, min_gap: lead_min});
        end
    endtask

    task automatic wait_idle(input int max_clk);
        int n = 0;
        while (busy && n < max_clk) begin
            tick(1);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    // Monitor: collects each strobe and the idle gap before it
    int   gap_clk = 0, gap_cen = 0, g_clk = 0, g_cen = 0, s_cen = 0;
    bit   in_stb = 1'b0;
    logic s_addr;
    logic [7:0] s_din;
    always @(negedge clk) begin
        if (rst) begin
            in_stb  = 1'b0;
            gap_clk = 0;
            gap_cen = 0;
        end else if (!opl_cs_n) begin
            chk("wr_n_eq_cs_n", int'(opl_wr_n), int'(opl_cs_n));
            if (!in_stb) begin
                in_stb = 1'b1;
                s_addr = opl_addr;
                s_din  = opl_din;
                s_cen  = int'(cen);
                g_clk  = gap_clk;
                g_cen  = gap_cen;
            end else begin
                chk("stb_stable", int'({opl_addr, opl_din}), int'({s_addr, s_din}));
                s_cen += int'(cen);
            end
        end else begin
            if (in_stb) begin
                exp_t e;
                in_stb = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", int'({s_addr, s_din}), -1);
                end else begin
                    e = sb.pop_front();
                    chk("stb_port", int'(s_addr), e.a);
                    chk("stb_din", int'(s_din), e.d);
                    chk("stb_cen_span", s_cen, 1);
                    if (e.gap_cen >= 0) chk("gap_cen", g_cen, e.gap_cen);
                    if (e.gap_clk >= 0) chk("gap_clk", g_clk, e.gap_clk);
                    if (e.min_gap > 0) chk("gap_min_ok", int'(g_cen >= e.min_gap), 1);
                end
                gap_clk = 0;
                gap_cen = 0;
            end
            gap_clk++;
            gap_cen += int'(cen);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick(3);
        chk("rst_cs_n", int'(opl_cs_n), 1);
        chk("rst_wr_n", int'(opl_wr_n), 1);
        chk("rst_addr", int'(opl_addr), 0);
        chk("rst_din", int'(opl_din), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(req_ready), 1);
        rst = 1'b0;
        tick(2);

        // 1: single write, cen always high, exact timeline from push edge t
        exp_wr(8'h20, 8'h21, 1'b1, 0, int'(OPL_AW_WAIT));
        push_one(8'h20, 8'h21);
        chk("t0_busy", int'(busy), 1);
        tick(1);
        chk("t1_cs_n", int'(opl_cs_n), 1);
        tick(1);
        chk("t2_cs_n", int'(opl_cs_n), 0);
        chk("t2_addr", int'(opl_addr), 0);
        chk("t2_din", int'(opl_din), 8'h20);
        tick(1);
        chk("t3_cs_n", int'(opl_cs_n), 1);
        tick(int'(OPL_AW_WAIT) - 1);
        chk("t14_cs_n", int'(opl_cs_n), 1);
        tick(1);
        chk("t15_cs_n", int'(opl_cs_n), 0);
        chk("t15_addr", int'(opl_addr), 1);
        chk("t15_din", int'(opl_din), 8'h21);
        tick(1);
        chk("t16_cs_n", int'(opl_cs_n), 1);
        tick(int'(OPL_DW_WAIT) - 1);
        chk("t99_busy", int'(busy), 1);
        tick(1);
        chk("t100_busy", int'(busy), 0);

        // 2: fill the FIFO while the lead write is in its data wait
        exp_wr(8'h30, 8'h31, 1'b1, int'(OPL_DW_WAIT), int'(OPL_AW_WAIT));
        push_one(8'h30, 8'h31);
        tick(19);
        for (int i = 0; i < 8; i++) begin
            exp_wr(8'h40 + i, 8'h50 + i, 1'b1, int'(OPL_DW_WAIT), int'(OPL_AW_WAIT));
            push_one(8'h40 + i, 8'h50 + i);
        end
        chk("full_level", int'(level), 8);
        chk("full_ready", int'(req_ready), 0);
        push_one(8'h48, 8'h58);
        chk("refused_level", int'(level), 8);
        chk("refused_ready", int'(req_ready), 0);
        wait_idle(1500);

        // 3: cen every 4th clock
        cen_div = 4;
        tick(2);
        exp_wr(8'h60, 8'h61, 1'b1, int'(OPL_DW_WAIT), 4 * int'(OPL_AW_WAIT));
        push_one(8'h60, 8'h61);
        wait_idle(1000);
        cen_div = 1;
        tick(2);

        // 4: same register twice skips the address; flush re-arms it
        exp_wr(8'hA0, 8'h11, 1'b1, int'(OPL_DW_WAIT), int'(OPL_AW_WAIT));
        exp_wr(8'hA0, 8'h22, 1'b0, int'(OPL_DW_WAIT), int'(OPL_AW_WAIT));
        push_one(8'hA0, 8'h11);
        push_one(8'hA0, 8'h22);
        wait_idle(500);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        exp_wr(8'hA0, 8'h33, 1'b1, int'(OPL_DW_WAIT), int'(OPL_AW_WAIT));
        push_one(8'hA0, 8'h33);
        wait_idle(500);

        // 5: flush during the data wait with three queued
        exp_wr(8'hB0, 8'hB1, 1'b1, int'(OPL_DW_WAIT), int'(OPL_AW_WAIT));
        push_one(8'hB0, 8'hB1);
        push_one(8'hC0, 8'hC8);
        push_one(8'hC1, 8'hC9);
        push_one(8'hC2, 8'hCA);
        chk("q3_level", int'(level), 3);
        tick(26);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_level", int'(level), 0);
        chk("flush_busy", int'(busy), 1);
        tick(69);
        chk("flush_t99_busy", int'(busy), 1);
        tick(1);
        chk("flush_t100_busy", int'(busy), 0);
        tick(300);
        chk("flush_quiet_busy", int'(busy), 0);

        // 6: reset while the address strobe is held (cen off)
        cen_div = 0;
        tick(3);
        push_one(8'hD0, 8'hD1);
        push_one(8'hD2, 8'hD3);
        chk("pre_rst_level", int'(level), 1);
        tick(1);
        chk("astb_cs_n", int'(opl_cs_n), 0);
        chk("astb_din", int'(opl_din), 8'hD0);
        rst = 1'b1;
        tick(1);
        chk("midrst_cs_n", int'(opl_cs_n), 1);
        chk("midrst_wr_n", int'(opl_wr_n), 1);
        chk("midrst_level", int'(level), 0);
        chk("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        cen_div = 1;
        tick(3);
        exp_wr(8'hE0, 8'hE1, 1'b1, 0, int'(OPL_AW_WAIT));
        push_one(8'hE0, 8'hE1);
        wait_idle(500);

        tick(10);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
